// File: rtl/mux2_1.sv
// mux2_1: parameterised 2:1 datapath multiplexer.
//   y          - combinational select (s ? d1 : d0), independent of clk/rst.
//   y_q, s_q   - registered selection and select, one-cycle latency.
//   toggle_cnt - saturating count of cycles where s differs from s_q.
// Optional build macro MUX2_1_PARITY_EN adds par_q, the registered
// XOR-reduction of the selected data, aligned with y_q.
module mux2_1 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             s_q,
`ifdef MUX2_1_PARITY_EN
    output logic             par_q,
`endif
    output logic [CNT_W-1:0] toggle_cnt
);

    logic [WIDTH-1:0] y_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             toggle;

    // Select data; an unknown select yields X rather than favouring one input.
    always_comb begin
        y = 'x;
        if (s)
            y = d1;
        else if (!s)
            y = d0;
    end

    assign y_d        = y;
    assign toggle     = (s != s_q);
    assign toggle_cnt = cnt_q;

    // Register the selection and the select that produced it.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
            s_q <= 1'b0;
        end else begin
            y_q <= y_d;
            s_q <= s;
        end
    end

    // Next toggle count: step on a select change, hold once all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (toggle && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Toggle counter register.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

`ifdef MUX2_1_PARITY_EN
    logic par_d;

    assign par_d = ^y_d;

    // Parity of the selected data, aligned with y_q.
    always_ff @(posedge clk) begin
        if (rst)
            par_q <= 1'b0;
        else
            par_q <= par_d;
    end
`endif

endmodule

// File: tb/tb_mux2_1.sv
// Directed testbench for mux2_1: a CNT_W=16 instance plus a CNT_W=4
// instance sharing the same stimulus to exercise counter saturation.
module tb_mux2_1;

    logic       clk;
    logic       rst;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       s;
    logic [7:0] y, y_q;
    logic       s_q;
    logic [15:0] toggle_cnt;
    logic [7:0] ys, ys_q;
    logic       ss_q;
    logic [3:0] sat_cnt;
`ifdef MUX2_1_PARITY_EN
    logic       par_q;
    logic       par_s;
`endif

    int checks;
    int failures;

    mux2_1 #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .d0(d0), .d1(d1), .s(s),
        .y(y), .y_q(y_q), .s_q(s_q),
`ifdef MUX2_1_PARITY_EN
        .par_q(par_q),
`endif
        .toggle_cnt(toggle_cnt)
    );

    mux2_1 #(.WIDTH(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .d0(d0), .d1(d1), .s(s),
        .y(ys), .y_q(ys_q), .s_q(ss_q),
`ifdef MUX2_1_PARITY_EN
        .par_q(par_s),
`endif
        .toggle_cnt(sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s = 1'b1; d0 = 8'h00; d1 = 8'hFF;
        #1;
        checks++;
        if (y !== 8'hFF) begin failures++; $display("FAIL reset_y_comb got=%h exp=%h", y, 8'hFF); end
        tick();
        checks++;
        if (y_q !== 8'h00 || s_q !== 1'b0 || toggle_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_edge1 got y_q=%h s_q=%b cnt=%0d exp 00/0/0", y_q, s_q, toggle_cnt);
        end
        checks++;
        if (y !== 8'hFF) begin failures++; $display("FAIL reset_y_hold got=%h exp=%h", y, 8'hFF); end
        tick();
        checks++;
        if (y_q !== 8'h00 || s_q !== 1'b0 || toggle_cnt !== 16'd0 || y !== 8'hFF) begin
            failures++;
            $display("FAIL reset_edge2 got y=%h y_q=%h s_q=%b cnt=%0d exp FF/00/0/0", y, y_q, s_q, toggle_cnt);
        end
`ifdef MUX2_1_PARITY_EN
        checks++;
        if (par_q !== 1'b0) begin failures++; $display("FAIL reset_par got=%b exp=0", par_q); end
`endif
    endtask

    task automatic test_select();
        rst = 1'b1; tick();
        rst = 1'b0; d0 = 8'h9A; d1 = 8'h75; s = 1'b1;
        #1;
        checks++;
        if (y !== 8'h75) begin failures++; $display("FAIL sel1_y got=%h exp=%h", y, 8'h75); end
        tick();
        checks++;
        if (y_q !== 8'h75 || s_q !== 1'b1 || toggle_cnt !== 16'd1) begin
            failures++;
            $display("FAIL sel1_reg got y_q=%h s_q=%b cnt=%0d exp 75/1/1", y_q, s_q, toggle_cnt);
        end
`ifdef MUX2_1_PARITY_EN
        checks++;
        if (par_q !== 1'b1) begin failures++; $display("FAIL par_75 got=%b exp=1", par_q); end
`endif
        s = 1'b0;
        #1;
        checks++;
        if (y !== 8'h9A) begin failures++; $display("FAIL sel0_y got=%h exp=%h", y, 8'h9A); end
        tick();
        checks++;
        if (y_q !== 8'h9A || s_q !== 1'b0 || toggle_cnt !== 16'd2) begin
            failures++;
            $display("FAIL sel0_reg got y_q=%h s_q=%b cnt=%0d exp 9a/0/2", y_q, s_q, toggle_cnt);
        end
`ifdef MUX2_1_PARITY_EN
        checks++;
        if (par_q !== 1'b0) begin failures++; $display("FAIL par_9a got=%b exp=0", par_q); end
`endif
        // Steady select: no further counting.
        tick();
        checks++;
        if (toggle_cnt !== 16'd2) begin failures++; $display("FAIL hold_cnt got=%0d exp=2", toggle_cnt); end
    endtask

    task automatic test_alternate();
        logic [7:0] exp_y;
        rst = 1'b1; tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s  = (i % 2 == 0);
            d0 = 8'(8'h10 + i);
            d1 = 8'(8'hC0 + i);
            exp_y = s ? d1 : d0;
            tick();
            checks++;
            if (y_q !== exp_y || s_q !== s) begin
                failures++;
                $display("FAIL alt_track[%0d] got y_q=%h s_q=%b exp %h/%b", i, y_q, s_q, exp_y, s);
            end
        end
        checks++;
        if (toggle_cnt !== 16'd10) begin failures++; $display("FAIL alt_cnt got=%0d exp=10", toggle_cnt); end
    endtask

    task automatic test_saturate();
        rst = 1'b1; tick();
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            s = (i % 2 == 1);
            tick();
            if (i == 14) begin
                checks++;
                if (sat_cnt !== 4'hE) begin failures++; $display("FAIL sat_14 got=%h exp=e", sat_cnt); end
            end
            if (i == 15) begin
                checks++;
                if (sat_cnt !== 4'hF) begin failures++; $display("FAIL sat_15 got=%h exp=f", sat_cnt); end
            end
        end
        checks++;
        if (sat_cnt !== 4'hF) begin failures++; $display("FAIL sat_hold got=%h exp=f", sat_cnt); end
        checks++;
        if (toggle_cnt !== 16'd20) begin failures++; $display("FAIL wide_cnt got=%0d exp=20", toggle_cnt); end
        // Mid-operation reset clears everything on that edge.
        rst = 1'b1; tick();
        checks++;
        if (sat_cnt !== 4'h0 || toggle_cnt !== 16'd0 || s_q !== 1'b0) begin
            failures++;
            $display("FAIL midreset got sat=%h cnt=%0d s_q=%b exp 0/0/0", sat_cnt, toggle_cnt, s_q);
        end
        rst = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; s = 1'b0; d0 = '0; d1 = '0;
        #1;
        test_reset();
        test_select();
        test_reset();
        test_alternate();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux2_1.md
Name: mux2_1

Overview:
- Parameterised 2:1 data multiplexer used in the processor datapath for operand and writeback selection.
- Combinational output `y` selects `d1` when `s`=1 and `d0` when `s`=0.
- A registered copy of the selected data and a select-toggle statistics counter are kept in the single clock domain for pipelined consumers and debug.

Parameters:
- WIDTH, 8, data width of d0, d1, y, y_q.
- CNT_W, 16, width of the select-toggle counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- d0  input  WIDTH  data input selected when s=0.
- d1  input  WIDTH  data input selected when s=1.
- s  input  1  select.
- y  output  WIDTH  combinational mux output.
- y_q  output  WIDTH  registered mux output, one-cycle latency.
- s_q  output  1  registered copy of s, aligned with y_q.
- toggle_cnt  output  CNT_W  count of cycles where s differs from s_q.

Behaviour:
- `y` is purely combinational: y = s ? d1 : d0.
  - Zero latency; it follows any input change within the same delta.
  - It is independent of clk and rst, including during reset.
- If `s` is X or Z, `y` is driven X (simulation only). There is no default priority.
- `y_q` and `s_q` on each rising edge of clk:
  - If rst=1: y_q <= 0 and s_q <= 0.
  - Otherwise: y_q <= (s ? d1 : d0) and s_q <= s.
- `toggle_cnt` on each rising edge:
  - If rst=1: cleared to 0.
  - Else if s != s_q: increments by 1.
  - It saturates at all-ones (2^CNT_W-1) and never wraps.
- The first cycle after reset release counts a toggle if s=1, because s_q resets to 0.
- Reset asserted mid-operation clears all registered outputs on that edge. `y` is unaffected.
- All widths are exact. There is no sign extension or truncation on any path.

Optional Feature:
- Macro: MUX2_1_PARITY_EN.
- When defined:
  - Adds output port `par_q` (1 bit).
  - par_q is registered, equal to the XOR-reduction of the selected data, and aligned with y_q.
  - par_q resets to 0 on rst.
- When undefined: the port `par_q` and its logic are absent. All other behaviour is identical.

Test Plan:
- d0=8'h9A, d1=8'h75, s=1 -> y=8'h75 immediately; y_q=8'h75 after the next rising edge.
- Same data, s=0 -> y=8'h9A immediately; y_q=8'h9A one edge later; toggle_cnt increments by 1 on that edge.
- rst=1 for 2 cycles with s=1, d1=8'hFF -> y=8'hFF throughout; y_q=0, s_q=0, toggle_cnt=0 after the first reset edge.
- s alternating every cycle for 10 cycles after reset -> toggle_cnt=10; y_q tracks the prior-cycle selection each cycle.
- CNT_W=4, s toggled for 20 cycles -> toggle_cnt saturates at 4'hF and holds.
- MUX2_1_PARITY_EN defined:
  - Selected 8'h75 -> par_q=1.
  - Selected 8'h9A -> par_q=0.
